if_id_stage_reg: RTL and testbench
==================================

# if_id_stage_reg

- **Position:** IF/ID pipeline register. Sits between the fetch stage (PC register, NPC register, +4 adder, instruction memory) and decode.
- **Captures:** the fetched instruction, its PC and its NPC.
- **Pipeline control:** stall, exception flush and SPARC-style delayed-branch annulment.
- **Outputs to decode:** a valid flag, a delay-slot marker and a saturating squash counter.

## Interface
Parameters:
- NOP_WORD, 32'h0000_0000, instruction word driven on squashed slots
- CNT_W, 16, squash counter width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- instr_in  input  32  instruction from instruction memory
- pc_in  input  32  PC of instr_in
- npc_in  input  32  NPC of instr_in (NPC register output)
- stall  input  1  hold all registers and state
- flush  input  1  exception/redirect; squash unconditionally
- branch_taken  input  1  decode: instruction in ID is a taken CTI; may be held high across stalls
- annul  input  1  qualifies branch_taken: squash the delay slot
- instr_out  output  32  instruction to decode
- pc_out  output  32  PC of instr_out
- npc_out  output  32  NPC of instr_out
- valid_out  output  1  instr_out is a real instruction
- in_delay_slot  output  1  instr_out is the delay slot of a taken CTI
- dcti_err  output  1  one-cycle pulse: taken CTI seen in a delay slot (ignored)
- squash_count  output  CNT_W  saturating count of squashed slots

## Operation
- **Reset values:**
  - instr_out=NOP_WORD, pc_out=0, npc_out=4
  - valid_out=0, in_delay_slot=0, dcti_err=0, squash_count=0
  - state=RUN
- **FSM states:**
  - RUN: normal operation.
  - SLOT: ID holds a delay slot.
  - DRAIN: the one wrong-path fetch after a flush.
- **Per-edge priority:** flush > stall > FSM action.
- **flush (any state):**
  - Load NOP_WORD, valid_out=0, in_delay_slot=0.
  - pc_out and npc_out take pc_in and npc_in.
  - squash_count++.
  - Next state DRAIN.
- **stall (without flush):**
  - All outputs and state hold.
  - dcti_err forced 0.
- **RUN:**
  - branch_taken=0: load the inputs, valid_out=1, in_delay_slot=0. Stay in RUN.
  - branch_taken=1, annul=0: load the inputs, valid_out=1, in_delay_slot=1. Go to SLOT.
  - branch_taken=1, annul=1: load NOP_WORD with pc_in/npc_in, valid_out=0, in_delay_slot=1, squash_count++. Go to SLOT.
- **SLOT:**
  - Load the inputs normally, valid_out=1, in_delay_slot=0. Go to RUN.
  - If branch_taken=1: it is ignored, dcti_err=1 for one cycle, and no second slot is marked.
- **DRAIN:**
  - Load NOP_WORD, valid_out=0, squash_count++. Go to RUN.
  - branch_taken is ignored.
- **squash_count:**
  - Saturates at all-ones and never wraps.
  - Increments only on loading edges.
- **Other outputs:** dcti_err is 0 on every edge not described above.

## Timing
- Latency: one clk. Outputs change only on posedge clk or on reset assertion.
- All outputs are registered. There are no combinational paths from input to output.
- branch_taken held high across N stall cycles is acted on exactly once, at the first non-stalled edge.
- Reset asserted mid-operation (any state, including SLOT or DRAIN):
  - Immediate return to the reset values.
  - The pending slot and drain are lost.
  - squash_count clears.
- Deassertion of reset is synchronous to the next edge. The first loading edge after reset behaves as RUN.

## Test plan
- **Reset then sequential fetch:**
  - Stimulus: reset released; drive pc 0/4/8 and npc 4/8/12 on successive cycles.
  - Required: before the first edge, outputs read NOP/0/4/valid=0. Afterwards, outputs follow the inputs one cycle late with valid_out=1.
- **Taken branch without annul:**
  - Stimulus: branch_taken=1, annul=0 with instr_in=32'hA.
  - Required: next cycle instr_out=32'hA with in_delay_slot=1. The cycle after, in_delay_slot=0. squash_count stays 0.
- **Annulled branch held over a 2-cycle stall:**
  - Stimulus: branch_taken=1, annul=1, stall=1 for 2 cycles.
  - Required: outputs frozen during the stall. Then exactly one NOP slot with valid_out=0 and squash_count=1.
- **Flush coinciding with stall and branch_taken:**
  - Stimulus: flush, stall and branch_taken all high on the same edge.
  - Required: NOP with valid_out=0. The next edge is also NOP (DRAIN). squash_count=2, then normal loading resumes.
- **DCTI couple:**
  - Stimulus: branch_taken=1 on two consecutive unstalled edges.
  - Required: the second yields dcti_err=1 for exactly one cycle and in_delay_slot=0.
- **Saturation and async reset:**
  - Stimulus: with CNT_W=4, apply 20 flushes. Then assert reset between clock edges while in SLOT.
  - Required: squash_count stops at 15. On reset, outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/if_id_stage_reg_if.sv
// IF/ID bundle: fetch-side inputs and control flowing into the stage, and
// the registered decode-side outputs flowing out of it.
//
// Handshake: there is no valid/ready pair on the fetch side. The stage takes
// a new slot on every posedge where stall=0 (stall is the inverse of ready).
// valid_out qualifies instr_out towards decode; a squashed slot still carries
// pc_out/npc_out, but valid_out=0.
interface if_id_stage_reg_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_in;
  logic [31:0]      pc_in;
  logic [31:0]      npc_in;
  logic             stall;
  logic             flush;
  logic             branch_taken;
  logic             annul;
  logic [31:0]      instr_out;
  logic [31:0]      pc_out;
  logic [31:0]      npc_out;
  logic             valid_out;
  logic             in_delay_slot;
  logic             dcti_err;
  logic [CNT_W-1:0] squash_count;

  // Fetch/control side (the testbench or the surrounding pipeline).
  modport master (
    output instr_in, pc_in, npc_in, stall, flush, branch_taken, annul,
    input  instr_out, pc_out, npc_out, valid_out, in_delay_slot, dcti_err,
           squash_count
  );

  // The pipeline register itself.
  modport slave (
    input  instr_in, pc_in, npc_in, stall, flush, branch_taken, annul,
    output instr_out, pc_out, npc_out, valid_out, in_delay_slot, dcti_err,
           squash_count
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with stall, exception flush and SPARC-style
// delayed-branch annulment. All outputs come straight from flops.
// Edge priority: flush > stall > FSM action.
module if_id_stage_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  if_id_stage_reg_if.slave     bus,
  output logic [1:0]           state_dbg
);

  // RUN: normal; SLOT: ID holds a delay slot; DRAIN: wrong-path fetch after flush.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLOT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      npc_q, npc_d;
  logic             valid_q, valid_d;
  logic             slot_q, slot_d;
  logic             dcti_q, dcti_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment: stays at all-ones instead of wrapping.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and next-output logic for the stage.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    slot_d  = slot_q;
    dcti_d  = 1'b0;
    cnt_d   = cnt_q;

    if (bus.flush) begin
      instr_d = NOP_WORD;
      pc_d    = bus.pc_in;
      npc_d   = bus.npc_in;
      valid_d = 1'b0;
      slot_d  = 1'b0;
      cnt_d   = cnt_inc;
      state_d = DRAIN;
    end else if (bus.stall) begin
      // Hold everything; a branch_taken held across the stall is seen
      // again on the first unstalled edge and acted on only there.
    end else begin
      pc_d  = bus.pc_in;
      npc_d = bus.npc_in;
      case (state_q)
        RUN: begin
          if (bus.branch_taken && bus.annul) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            slot_d  = 1'b1;
            cnt_d   = cnt_inc;
            state_d = SLOT;
          end else if (bus.branch_taken) begin
            instr_d = bus.instr_in;
            valid_d = 1'b1;
            slot_d  = 1'b1;
            state_d = SLOT;
          end else begin
            instr_d = bus.instr_in;
            valid_d = 1'b1;
            slot_d  = 1'b0;
          end
        end
        SLOT: begin
          // A taken CTI sitting in a delay slot is ignored and flagged.
          instr_d = bus.instr_in;
          valid_d = 1'b1;
          slot_d  = 1'b0;
          dcti_d  = bus.branch_taken;
          state_d = RUN;
        end
        DRAIN: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          slot_d  = 1'b0;
          cnt_d   = cnt_inc;
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      instr_q <= NOP_WORD;
      pc_q    <= 32'd0;
      npc_q   <= 32'd4;
      valid_q <= 1'b0;
      slot_q  <= 1'b0;
      dcti_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      slot_q  <= slot_d;
      dcti_q  <= dcti_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instr_out     = instr_q;
  assign bus.pc_out        = pc_q;
  assign bus.npc_out       = npc_q;
  assign bus.valid_out     = valid_q;
  assign bus.in_delay_slot = slot_q;
  assign bus.dcti_err      = dcti_q;
  assign bus.squash_count  = cnt_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Testbench for if_id_stage_reg: directed vectors with hand-computed expected
// outputs pushed into a queue, popped by a monitor on the falling edge.
module tb_if_id_stage_reg;

  localparam int CNT_W = 4;
  localparam int W     = 32 * 3 + 3 + CNT_W + 2;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_SLOT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  if_id_stage_reg_if #(.CNT_W(CNT_W)) bus ();

  if_id_stage_reg #(.NOP_WORD(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic logic [W-1:0] mk(input logic [31:0] i, input logic [31:0] p,
                                      input logic [31:0] n, input logic v,
                                      input logic s, input logic d,
                                      input logic [CNT_W-1:0] c, input logic [1:0] st);
    return {i, p, n, v, s, d, c, st};
  endfunction

  function automatic logic [W-1:0] actual();
    return {bus.instr_out, bus.pc_out, bus.npc_out, bus.valid_out,
            bus.in_delay_slot, bus.dcti_err, bus.squash_count, state_dbg};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got instr/pc/npc/v/s/d/cnt/st=%h, expected %h", name, got, exp);
  endtask

  // Monitor: every falling edge presents one registered slot to decode.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, actual(), e);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input string name, input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] n, input logic st, input logic fl,
                      input logic bt, input logic an, input logic [W-1:0] exp);
    @(negedge clk);
    #1;
    bus.instr_in     = i;
    bus.pc_in        = p;
    bus.npc_in       = n;
    bus.stall        = st;
    bus.flush        = fl;
    bus.branch_taken = bt;
    bus.annul        = an;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #2;
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d expected slots never observed, required 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] c;
    reset            = 1'b1;
    bus.instr_in     = 32'h0;
    bus.pc_in        = 32'h0;
    bus.npc_in       = 32'h0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.annul        = 1'b0;

    #1;
    check("reset_state", actual(), mk(32'h0, 32'd0, 32'd4, 0, 0, 0, 0, S_RUN));
    #1 reset = 1'b0;

    // Sequential fetch
    step("seq0", 32'h11, 32'd0, 32'd4, 0, 0, 0, 0, mk(32'h11, 32'd0, 32'd4, 1, 0, 0, 0, S_RUN));
    step("seq1", 32'h22, 32'd4, 32'd8, 0, 0, 0, 0, mk(32'h22, 32'd4, 32'd8, 1, 0, 0, 0, S_RUN));
    step("seq2", 32'h33, 32'd8, 32'd12, 0, 0, 0, 0, mk(32'h33, 32'd8, 32'd12, 1, 0, 0, 0, S_RUN));

    // Taken branch without annul
    step("br_slot", 32'hA, 32'd12, 32'd16, 0, 0, 1, 0, mk(32'hA, 32'd12, 32'd16, 1, 1, 0, 0, S_SLOT));
    step("br_after", 32'h44, 32'd16, 32'd20, 0, 0, 0, 0, mk(32'h44, 32'd16, 32'd20, 1, 0, 0, 0, S_RUN));

    // Annulled branch held across a 2-cycle stall
    step("stall0", 32'h55, 32'd20, 32'd24, 1, 0, 1, 1, mk(32'h44, 32'd16, 32'd20, 1, 0, 0, 0, S_RUN));
    step("stall1", 32'h55, 32'd20, 32'd24, 1, 0, 1, 1, mk(32'h44, 32'd16, 32'd20, 1, 0, 0, 0, S_RUN));
    step("annul_nop", 32'h55, 32'd20, 32'd24, 0, 0, 1, 1, mk(32'h0, 32'd20, 32'd24, 0, 1, 0, 1, S_SLOT));
    step("annul_after", 32'h66, 32'd24, 32'd28, 0, 0, 0, 0, mk(32'h66, 32'd24, 32'd28, 1, 0, 0, 1, S_RUN));

    // Flush together with stall and branch_taken, then DRAIN
    step("flush", 32'h77, 32'd28, 32'd32, 1, 1, 1, 0, mk(32'h0, 32'd28, 32'd32, 0, 0, 0, 2, S_DRAIN));
    step("drain", 32'h88, 32'd32, 32'd36, 0, 0, 1, 0, mk(32'h0, 32'd32, 32'd36, 0, 0, 0, 3, S_RUN));
    step("resume", 32'h99, 32'd36, 32'd40, 0, 0, 0, 0, mk(32'h99, 32'd36, 32'd40, 1, 0, 0, 3, S_RUN));

    // DCTI couple
    step("dcti_first", 32'hB1, 32'd40, 32'd44, 0, 0, 1, 0, mk(32'hB1, 32'd40, 32'd44, 1, 1, 0, 3, S_SLOT));
    step("dcti_second", 32'hB2, 32'd44, 32'd48, 0, 0, 1, 0, mk(32'hB2, 32'd44, 32'd48, 1, 0, 1, 3, S_RUN));
    step("dcti_clear", 32'hB3, 32'd48, 32'd52, 0, 0, 0, 0, mk(32'hB3, 32'd48, 32'd52, 1, 0, 0, 3, S_RUN));

    // 20 flushes: count goes 4..15 and then sticks at 15
    for (int k = 1; k <= 20; k++) begin
      c = (3 + k > 15) ? CNT_W'(15) : CNT_W'(3 + k);
      step($sformatf("sat_flush%0d", k), 32'hC0 + k, 32'd200 + 4 * k, 32'd204 + 4 * k,
           0, 1, 0, 0, mk(32'h0, 32'd200 + 4 * k, 32'd204 + 4 * k, 0, 0, 0, c, S_DRAIN));
    end
    step("sat_drain", 32'hD0, 32'd100, 32'd104, 0, 0, 0, 0, mk(32'h0, 32'd100, 32'd104, 0, 0, 0, 15, S_RUN));
    step("pre_rst_slot", 32'hD1, 32'd104, 32'd108, 0, 0, 1, 0, mk(32'hD1, 32'd104, 32'd108, 1, 1, 0, 15, S_SLOT));
    step("idle", 32'hD2, 32'd108, 32'd112, 1, 0, 0, 0, mk(32'hD1, 32'd104, 32'd108, 1, 1, 0, 15, S_SLOT));
    wait_drain();

    // Asynchronous reset between edges while in SLOT
    #1 reset = 1'b1;
    #1;
    check("async_reset", actual(), mk(32'h0, 32'd0, 32'd4, 0, 0, 0, 0, S_RUN));
    @(negedge clk);
    #1 reset = 1'b0;

    // First loading edge after reset behaves as RUN
    step("post_rst0", 32'hE0, 32'd0, 32'd4, 0, 0, 0, 0, mk(32'hE0, 32'd0, 32'd4, 1, 0, 0, 0, S_RUN));
    step("post_rst1", 32'hE1, 32'd4, 32'd8, 0, 0, 1, 1, mk(32'h0, 32'd4, 32'd8, 0, 1, 0, 1, S_SLOT));
    step("post_rst2", 32'hE2, 32'd8, 32'd12, 1, 0, 0, 0, mk(32'h0, 32'd4, 32'd8, 0, 1, 0, 1, S_SLOT));
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
